if_id_skid_stage: RTL and testbench

- Parametrised successor to the fetch/decode pipeline register.
- Replaces the bare stall/flush register with a valid/ready handshake stage:
  - optional two-entry skid buffer, so ready can be registered without losing throughput;
  - flush injects a canonical NOP bubble;
  - saturating performance counters.
- Sits between the fetch unit (upstream) and decode (downstream); hazard logic drives `i_flush` and backpressure arrives as `i_ready`.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/sat_counter.sv | 33 +++
 rtl/if_id_skid_stage.sv | 133 +++++++++++++
 tb/tb_if_id_skid_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions for the IF/ID and later stage registers.
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..3 increment and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_clr_n,
  input  logic         inc_en,
  input  logic [1:0]   inc_amt,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(W - 1){1'b0}}, inc_amt};
    cnt_d = cnt_q;
    if (inc_en) begin
      cnt_d = sum[W] ? '1 : sum[W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// Fetch/decode valid-ready stage with optional two-entry skid buffer, NOP flush
// bubble and saturating stall/flush counters.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned         PC_W     = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [INST_W-1:0]   NOP_INST = RV_NOP,
  parameter bit                  SKID     = 1'b1,
  parameter int unsigned         CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [1:0]        o_count,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  stage_state_e      state_q, state_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  assign o_valid = (state_q != EMPTY);
  assign o_ready = SKID ? ready_q : (!o_valid || i_ready);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (i_flush) begin
      state_d     = EMPTY;
      main_pc_d   = '0;
      main_inst_d = NOP_INST;
      skid_pc_d   = '0;
      skid_inst_d = NOP_INST;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_pc_d   = i_pc;
            main_inst_d = i_inst;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_pc_d   = i_pc;
            main_inst_d = i_inst;
          end else if (pop) begin
            state_d     = EMPTY;
            main_pc_d   = '0;
            main_inst_d = NOP_INST;
          end else if (push && SKID) begin
            state_d     = TWO;
            skid_pc_d   = i_pc;
            skid_inst_d = i_inst;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            skid_pc_d   = '0;
            skid_inst_d = NOP_INST;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered ready looks ahead at the next state so it drops right as TWO is entered.
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      ready_q     <= ready_d;
    end
  end

  assign o_pc    = main_pc_q;
  assign o_inst  = main_inst_q;
  assign o_count = state_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .inc_en  (o_valid && !i_ready),
    .inc_amt (2'd1),
    .o_cnt   (o_stall_cnt)
  );

  // Flush discards whatever is held at the edge, so count the occupancy.
  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clr_n (i_rst_n),
    .inc_en  (i_flush),
    .inc_amt (o_count),
    .o_cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Directed bench: SKID=1/CNT_W=4 instance for skid, flush and saturation; SKID=0 for backpressure.
module tb_if_id_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: SKID=1, CNT_W=4
  logic        a_flush, a_valid, a_ready_o, a_valid_o, a_ready;
  logic [31:0] a_pc, a_inst, a_pc_o, a_inst_o;
  logic [1:0]  a_count;
  logic [3:0]  a_stall, a_fcnt;

  // Instance B: SKID=0, CNT_W=16
  logic        b_flush, b_valid, b_ready_o, b_valid_o, b_ready;
  logic [31:0] b_pc, b_inst, b_pc_o, b_inst_o;
  logic [1:0]  b_count;
  logic [15:0] b_stall, b_fcnt;

  int n_checks = 0;
  int n_errors = 0;

  if_id_skid_stage #(
    .SKID  (1'b1),
    .CNT_W (4)
  ) dut_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (a_flush),
    .i_valid     (a_valid),
    .o_ready     (a_ready_o),
    .i_pc        (a_pc),
    .i_inst      (a_inst),
    .o_valid     (a_valid_o),
    .i_ready     (a_ready),
    .o_pc        (a_pc_o),
    .o_inst      (a_inst_o),
    .o_count     (a_count),
    .o_stall_cnt (a_stall),
    .o_flush_cnt (a_fcnt)
  );

  if_id_skid_stage #(
    .SKID  (1'b0),
    .CNT_W (16)
  ) dut_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_flush     (b_flush),
    .i_valid     (b_valid),
    .o_ready     (b_ready_o),
    .i_pc        (b_pc),
    .i_inst      (b_inst),
    .o_valid     (b_valid_o),
    .i_ready     (b_ready),
    .o_pc        (b_pc_o),
    .o_inst      (b_inst_o),
    .o_count     (b_count),
    .o_stall_cnt (b_stall),
    .o_flush_cnt (b_fcnt)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [31:0] pc);
    a_valid = 1'b1;
    a_pc    = pc;
    a_inst  = 32'hA000_0000 | pc;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_flush = 1'b0; a_valid = 1'b1; a_pc = 32'h100; a_inst = 32'hDEAD_BEEF; a_ready = 1'b1;
    b_flush = 1'b0; b_valid = 1'b1; b_pc = 32'h200; b_inst = 32'hDEAD_BEEF; b_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_valid", 32'(a_valid_o), 32'd0);
    check("rst_inst",  a_inst_o, NOP);
    check("rst_pc",    a_pc_o, 32'd0);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_ready", 32'(a_ready_o), 32'd1);
    check("rst_stall", 32'(a_stall), 32'd0);
    check("rst_fcnt",  32'(a_fcnt), 32'd0);
    check("rst_b_ready", 32'(b_ready_o), 32'd1);
    check("rst_b_valid", 32'(b_valid_o), 32'd0);
    rst_n   = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    step();
    check("post_rst_valid", 32'(a_valid_o), 32'd0);

    // Streaming at one per cycle
    a_push(32'h0); step();
    check("str0_valid", 32'(a_valid_o), 32'd1);
    check("str0_pc",    a_pc_o, 32'h0);
    check("str0_inst",  a_inst_o, 32'hA000_0000);
    a_push(32'h4); step();
    check("str1_pc",    a_pc_o, 32'h4);
    check("str1_ready", 32'(a_ready_o), 32'd1);
    a_push(32'h8); step();
    check("str2_pc",    a_pc_o, 32'h8);
    check("str2_count", 32'(a_count), 32'd1);
    a_valid = 1'b0; step();
    check("str_drain_valid", 32'(a_valid_o), 32'd0);
    check("str_drain_inst",  a_inst_o, NOP);
    check("str_drain_pc",    a_pc_o, 32'd0);
    check("str_stall",       32'(a_stall), 32'd0);

    // Skid fill under stall
    a_ready = 1'b0;
    a_push(32'h10); step();
    check("sk1_pc",    a_pc_o, 32'h10);
    check("sk1_ready", 32'(a_ready_o), 32'd1);
    a_push(32'h14); step();
    check("sk2_count", 32'(a_count), 32'd2);
    check("sk2_ready", 32'(a_ready_o), 32'd0);
    check("sk2_pc",    a_pc_o, 32'h10);
    check("sk2_stall", 32'(a_stall), 32'd1);
    a_valid = 1'b0; step();
    check("sk3_pc",    a_pc_o, 32'h10);
    check("sk3_inst",  a_inst_o, 32'hA000_0010);
    check("sk3_stall", 32'(a_stall), 32'd2);
    a_ready = 1'b1; step();
    check("sk_pop1_pc",    a_pc_o, 32'h14);
    check("sk_pop1_count", 32'(a_count), 32'd1);
    check("sk_pop1_ready", 32'(a_ready_o), 32'd1);
    step();
    check("sk_pop2_valid", 32'(a_valid_o), 32'd0);
    check("sk_stall_total", 32'(a_stall), 32'd2);

    // Flush from TWO while upstream still offers
    a_ready = 1'b0;
    a_push(32'h20); step();
    a_push(32'h24); step();
    check("fl_pre_count", 32'(a_count), 32'd2);
    a_flush = 1'b1;
    a_push(32'h28); step();
    check("fl2_valid", 32'(a_valid_o), 32'd0);
    check("fl2_inst",  a_inst_o, NOP);
    check("fl2_pc",    a_pc_o, 32'd0);
    check("fl2_count", 32'(a_count), 32'd0);
    check("fl2_fcnt",  32'(a_fcnt), 32'd2);
    check("fl2_ready", 32'(a_ready_o), 32'd1);
    check("fl2_stall", 32'(a_stall), 32'd4);
    a_flush = 1'b0; a_valid = 1'b0; step();
    check("fl2_absent", 32'(a_valid_o), 32'd0);

    // Flush from ONE with concurrent push and pop; next-cycle push accepted
    a_ready = 1'b1;
    a_push(32'h30); step();
    a_flush = 1'b1;
    a_push(32'h34); step();
    check("fl1_valid", 32'(a_valid_o), 32'd0);
    check("fl1_fcnt",  32'(a_fcnt), 32'd3);
    a_flush = 1'b0;
    a_push(32'h38); step();
    check("fl1_next_valid", 32'(a_valid_o), 32'd1);
    check("fl1_next_pc",    a_pc_o, 32'h38);
    a_valid = 1'b0; step();

    // Stall counter saturation at 4 bits
    a_ready = 1'b0;
    a_push(32'h40); step();
    a_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_stall", 32'(a_stall), 32'd15);
    step();
    check("sat_stall_hold", 32'(a_stall), 32'd15);
    check("sat_pc_held",    a_pc_o, 32'h40);
    a_flush = 1'b1; step();
    a_flush = 1'b0;
    check("sat_fcnt", 32'(a_fcnt), 32'd4);
    a_ready = 1'b1;

    // SKID=0 combinational backpressure
    b_valid = 1'b1; b_pc = 32'h50; b_inst = 32'hB000_0050; step();
    check("b_pc0",    b_pc_o, 32'h50);
    check("b_ready0", 32'(b_ready_o), 32'd1);
    b_ready = 1'b0;
    b_pc = 32'h54; b_inst = 32'hB000_0054;
    #1;
    check("b_ready_comb", 32'(b_ready_o), 32'd0);
    step();
    check("b_hold_pc",    b_pc_o, 32'h50);
    check("b_hold_count", 32'(b_count), 32'd1);
    check("b_stall",      32'(b_stall), 32'd1);
    b_ready = 1'b1;
    #1;
    check("b_ready_up", 32'(b_ready_o), 32'd1);
    step();
    check("b_repl_pc",    b_pc_o, 32'h54);
    check("b_repl_inst",  b_inst_o, 32'hB000_0054);
    check("b_repl_count", 32'(b_count), 32'd1);
    b_valid = 1'b0; step();
    check("b_drain_count", 32'(b_count), 32'd0);
    check("b_drain_inst",  b_inst_o, NOP);

    // Reset mid-operation drops entries without counting a flush
    a_ready = 1'b0;
    a_push(32'h60); step();
    a_valid = 1'b0;
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(a_valid_o), 32'd0);
    check("mid_rst_fcnt",  32'(a_fcnt), 32'd0);
    check("mid_rst_stall", 32'(a_stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
